mem_access_unit: RTL
====================

# mem_access_unit

Data-memory access engine for the MEM stage; it produces the `mdrreg_out`/`rmask` pair that the writeback stage consumes for load sign/zero extension. It takes a load or store from the EX/MEM packet and computes the word-aligned address, byte masks and lane-replicated store data. It then runs the read/write handshake with the data cache and stalls the pipeline until the access completes.

## Interface
Parameters:
- none (RV32I, 32-bit data, 4-byte lanes fixed)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous, active-low (0 = reset)
- `req_read`  in  1  packet valid and load; held stable while `stall` = 1
- `req_write`  in  1  packet valid and store; held stable while `stall` = 1
- `funct3`  in  3  width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- `addr`  in  32  byte address (alu_out)
- `store_data`  in  32  rs2 value
- `data_mem_address`  out  32  {addr[31:2], 2'b00}, registered
- `data_mem_read`  out  1  read request, registered
- `data_mem_write`  out  1  write request, registered
- `data_mem_wdata`  out  32  lane-replicated store data, registered
- `data_mem_wmask`  out  4  byte write enables, registered
- `data_mem_rdata`  in  32  read data, valid with `data_mem_resp`
- `data_mem_resp`  in  1  access complete
- `mdrreg_out`  out  32  captured read word (unshifted)
- `rmask`  out  4  load byte mask for writeback
- `wmask`  out  4  store byte mask for commit/trace
- `done`  out  1  one-cycle completion pulse
- `misaligned`  out  1  completion was an alignment fault; valid with `done`
- `stall`  out  1  freeze upstream pipeline registers (combinational)

## Operation
- States: IDLE, BUSY, DONE.
- IDLE with `req_write` or `req_read`:
  - Latch the address, masks and wdata.
  - If aligned, go to BUSY with `data_mem_write` set (when `req_write`) or `data_mem_read` set.
  - If misaligned, go to DONE with `misaligned` = 1 and no memory request.
- `req_write` and `req_read` together: treated as a write.
- BUSY: request held constant until `data_mem_resp`.
  - On resp: drop the request, capture `data_mem_rdata` into `mdrreg_out` (loads only; stores leave it unchanged), go to DONE.
- DONE: `done` = 1 for exactly this cycle, then return to IDLE unconditionally. Requests presented in DONE are ignored.
- `stall` = (IDLE and (`req_read` or `req_write`)) or BUSY. It is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Mask and data rules, with off = addr[1:0]:
  - b/bu: rmask = 4'b0001 << off.
  - h/hu: rmask = 4'b0011 << off.
  - w: rmask = 4'b1111.
  - sb: wmask = 4'b0001 << off; wdata = {4{store_data[7:0]}}.
  - sh: wmask = 4'b0011 << off; wdata = {2{store_data[15:0]}}.
  - sw: wmask = 4'b1111; wdata = store_data.
  - Loads drive wmask = 0. Stores drive rmask = 0.
- Misaligned:
  - h/hu/sh with addr[0] = 1.
  - w/sw with off != 0.
  - On a fault, rmask = wmask = 0 and `mdrreg_out` is unchanged.
- Illegal funct3 (011, 110, 111): treated as misaligned.
- `data_mem_resp` in IDLE or DONE: ignored.

## Timing
- Reset (`rst` = 0 at an edge): state IDLE. Outputs are 0 at the next edge: `data_mem_*`, `mdrreg_out`, `rmask`, `wmask`, `done`, `misaligned`.
- Reset mid-BUSY: the request drops at that edge. A late `data_mem_resp` is discarded.
- Latency with a response k cycles after request assertion (k ≥ 0; resp in the first BUSY cycle is k = 0):
  - Request seen in IDLE at cycle T.
  - `data_mem_read`/`data_mem_write` high from T+1 through T+1+k.
  - `done` at T+2+k.
  - `stall` high for T..T+1+k.
- Misaligned: `done` and `misaligned` at T+1; `stall` high only in T.
- Back-to-back: the next request is accepted in IDLE at T+3+k at the earliest.
- `mdrreg_out`/`rmask` stay valid from `done` until the next capture.

## Test plan
- lbu at addr 0x00000106, rdata 0xAABBCCDD, resp 2 cycles after request:
  - `data_mem_address` 0x00000104, read high 3 cycles, `rmask` 4'b0100.
  - `mdrreg_out` 0xAABBCCDD, `done` at T+4, stall 4 cycles.
- sh at addr 0x0000020A, store_data 0x1234ABCD, zero-wait resp:
  - wdata 0xABCDABCD, wmask 4'b1100, address 0x00000208.
  - Write high 1 cycle, `done` at T+2.
- lw at addr 0x00000301:
  - No read ever asserted; `done` = `misaligned` = 1 at T+1.
  - rmask 0, `mdrreg_out` unchanged.
- Reset mid-BUSY: sb pending, `rst` low one cycle, then resp arrives:
  - Write drops, state IDLE, no `done`, the stray resp is ignored.
- Back-to-back lw 0x0 then sw 0x4, with the request inputs held through DONE:
  - Exactly two accesses, one `done` each.
  - The second access starts at the cycle after the first DONE.
- Both `req_read` and `req_write` high at addr 0x10: only `data_mem_write` is asserted.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store engine with data cache handshake
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] data_mem_address,
    output logic        data_mem_read,
    output logic        data_mem_write,
    output logic [31:0] data_mem_wdata,
    output logic [3:0]  data_mem_wmask,
    input  logic [31:0] data_mem_rdata,
    input  logic        data_mem_resp,
    output logic [31:0] mdrreg_out,
    output logic [3:0]  rmask,
    output logic [3:0]  wmask,
    output logic        done,
    output logic        misaligned,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        is_store;
    logic        fault;
    logic [3:0]  lane_mask;
    logic [3:0]  acc_rmask;
    logic [3:0]  acc_wmask;
    logic [31:0] acc_wdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_read || req_write) begin
                    next_state = fault ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (data_mem_resp) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Width decode; a store wins when both request lines are high.
    always_comb begin
        lane_mask = 4'b0000;
        acc_wdata = 32'h0;
        fault     = 1'b0;
        is_store  = req_write;
        case (funct3[1:0])
            2'b00: begin
                lane_mask = 4'b0001 << addr[1:0];
                acc_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                lane_mask = 4'b0011 << addr[1:0];
                acc_wdata = {2{store_data[15:0]}};
                fault     = addr[0];
            end
            2'b10: begin
                lane_mask = 4'b1111;
                acc_wdata = store_data;
                fault     = |addr[1:0];
            end
            default: fault = 1'b1;
        endcase
        if (funct3[2] && funct3[1]) begin
            fault = 1'b1;
        end
        acc_rmask = (!is_store && !fault) ? lane_mask : 4'b0000;
        acc_wmask = (is_store && !fault) ? lane_mask : 4'b0000;
        accept    = (state == IDLE) && (req_read || req_write);
        stall     = accept || (state == BUSY);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_mem_address <= 32'h0;
            data_mem_read    <= 1'b0;
            data_mem_write   <= 1'b0;
            data_mem_wdata   <= 32'h0;
            data_mem_wmask   <= 4'b0000;
            mdrreg_out       <= 32'h0;
            rmask            <= 4'b0000;
            wmask            <= 4'b0000;
            done             <= 1'b0;
            misaligned       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_mem_address <= {addr[31:2], 2'b00};
                        data_mem_wdata   <= is_store ? acc_wdata : 32'h0;
                        data_mem_wmask   <= acc_wmask;
                        rmask            <= acc_rmask;
                        wmask            <= acc_wmask;
                        data_mem_read    <= !is_store && !fault;
                        data_mem_write   <= is_store && !fault;
                        done             <= fault;
                        misaligned       <= fault;
                    end
                end
                BUSY: begin
                    if (data_mem_resp) begin
                        data_mem_read  <= 1'b0;
                        data_mem_write <= 1'b0;
                        done           <= 1'b1;
                        if (data_mem_read) begin
                            mdrreg_out <= data_mem_rdata;
                        end
                    end
                end
                DONE: begin
                    done       <= 1'b0;
                    misaligned <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule
